// File: rtl/bus_xfer_ctrl_pkg.sv
// rtl/bus_xfer_ctrl_pkg.sv - shared state encoding, default sizes and register ids for the bus transfer controller
package bus_xfer_ctrl_pkg;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int IDW_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_REJ   = 3'd4
  } xfer_state_e;

  localparam logic [IDW_DEF-1:0] REG_ID_0 = 3'd0;
  localparam logic [IDW_DEF-1:0] REG_ID_7 = 3'd7;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_rr_arbiter.sv
// rtl/bus_xfer_ctrl_rr_arbiter.sv - combinational round-robin pick, first set request at or after the pointer
module rr_arbiter
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic            o_any_req,
  output logic [PW-1:0]   o_winner
);

  logic [PW:0] w_idx;

  always_comb begin
    o_any_req = 1'b0;
    o_winner  = i_rr_ptr;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_rr_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any_req && (w_idx == (PW+1)'(j)) && i_req[j]) begin
          o_any_req = 1'b1;
          o_winner  = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - arbitrated register-to-register transfer sequencer driving one-hot E/L enables
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*IDW-1:0] src_id,
  input  logic [NREQ*IDW-1:0] dst_id,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [NREG-1:0]     E,
  output logic [NREG-1:0]     L,
  output logic                busy
);

  localparam int PW = ptr_width(NREQ);

  xfer_state_e     r_state, w_nxt_state;
  logic [PW-1:0]   r_w, w_nxt_w;
  logic [PW-1:0]   r_rr_ptr, w_nxt_ptr;
  logic [IDW-1:0]  r_src, w_nxt_src;
  logic [IDW-1:0]  r_dst, w_nxt_dst;
  logic [IDW-1:0]  w_sel_src, w_sel_dst;
  logic            w_any_req, w_reject;
  logic [PW-1:0]   w_winner;

  logic [NREQ-1:0] r_gnt, r_done, w_gnt_n, w_done_n;
  logic [NREG-1:0] r_e, r_l, w_e_n, w_l_n;
  logic            r_err, r_busy, w_err_n, w_busy_n;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_any_req (w_any_req),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_sel_src = '0;
    w_sel_dst = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_winner == PW'(k)) begin
        w_sel_src = src_id[k*IDW +: IDW];
        w_sel_dst = dst_id[k*IDW +: IDW];
      end
    end
    w_reject = (w_sel_src == w_sel_dst)
            || ({1'b0, w_sel_src} >= (IDW+1)'(NREG))
            || ({1'b0, w_sel_dst} >= (IDW+1)'(NREG));
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_w     = r_w;
    w_nxt_src   = r_src;
    w_nxt_dst   = r_dst;
    w_nxt_ptr   = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_nxt_w     = w_winner;
          w_nxt_src   = w_sel_src;
          w_nxt_dst   = w_sel_dst;
          w_nxt_ptr   = (w_winner == PW'(NREQ-1)) ? '0 : w_winner + 1'b1;
          w_nxt_state = w_reject ? ST_REJ : ST_DRIVE;
        end
      end
      ST_DRIVE: w_nxt_state = ST_LOAD;
      ST_LOAD:  w_nxt_state = ST_DONE;
      ST_DONE:  w_nxt_state = ST_IDLE;
      ST_REJ:   w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they sit in flops aligned with the state register.
  always_comb begin
    w_gnt_n  = '0;
    w_done_n = '0;
    w_e_n    = '0;
    w_l_n    = '0;
    w_err_n  = (w_nxt_state == ST_REJ);
    w_busy_n = (w_nxt_state != ST_IDLE);
    for (int k = 0; k < NREQ; k++) begin
      if (w_nxt_w == PW'(k)) begin
        w_gnt_n[k]  = w_nxt_state inside {ST_DRIVE, ST_LOAD, ST_DONE};
        w_done_n[k] = w_nxt_state inside {ST_DONE, ST_REJ};
      end
    end
    for (int k = 0; k < NREG; k++) begin
      w_e_n[k] = (w_nxt_src == IDW'(k)) && (w_nxt_state inside {ST_DRIVE, ST_LOAD});
      w_l_n[k] = (w_nxt_dst == IDW'(k)) && (w_nxt_state == ST_LOAD);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_w      <= '0;
      r_rr_ptr <= '0;
      r_src    <= REG_ID_0;
      r_dst    <= REG_ID_0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_e      <= '0;
      r_l      <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_w      <= w_nxt_w;
      r_rr_ptr <= w_nxt_ptr;
      r_src    <= w_nxt_src;
      r_dst    <= w_nxt_dst;
      r_gnt    <= w_gnt_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_e      <= w_e_n;
      r_l      <= w_l_n;
      r_busy   <= w_busy_n;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign err  = r_err;
  assign E    = r_e;
  assign L    = r_l;
  assign busy = r_busy;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - bench for bus_xfer_ctrl with a transaction-level model and an 8-entry register file
module tb_bus_xfer_ctrl;

  logic        clk, clr;
  logic [3:0]  req, gnt, done;
  logic [11:0] src_id, dst_id;
  logic        err, busy;
  logic [7:0]  E, L;

  logic [3:0]  req6, gnt6, done6;
  logic [11:0] src6, dst6;
  logic        err6, busy6;
  logic [5:0]  E6, L6;

  bus_xfer_ctrl #(.NREQ(4), .NREG(8), .IDW(3)) u_dut (
    .clk(clk), .clr(clr), .req(req), .src_id(src_id), .dst_id(dst_id),
    .gnt(gnt), .done(done), .err(err), .E(E), .L(L), .busy(busy)
  );

  bus_xfer_ctrl #(.NREQ(4), .NREG(6), .IDW(3)) u_dut6 (
    .clk(clk), .clr(clr), .req(req6), .src_id(src6), .dst_id(dst6),
    .gnt(gnt6), .done(done6), .err(err6), .E(E6), .L(L6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [8];
  logic [7:0] m_regs [8];
  int  m_p, m_w, m_src, m_dst, m_ptr;
  bit  m_rej;

  typedef struct {
    logic [3:0] req;
    int src;
    int dst;
    int w;
    int err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_p = 0; m_ptr = 0; m_rej = 0; m_w = 0; m_src = 0; m_dst = 0;
  endtask

  task automatic model_edge();
    bit found;
    if (m_p == 0) begin
      if (req != 4'b0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            found = 1;
            m_w = (m_ptr + k) % 4;
          end
        end
        m_src = int'((src_id >> (3 * m_w)) & 12'h7);
        m_dst = int'((dst_id >> (3 * m_w)) & 12'h7);
        m_ptr = (m_w + 1) % 4;
        m_rej = (m_src == m_dst) || (m_src >= 8) || (m_dst >= 8);
        m_p = 1;
      end
    end else if (m_rej || m_p == 3) begin
      m_p = 0;
    end else begin
      if (m_p == 2) m_regs[m_dst] = m_regs[m_src];
      m_p++;
    end
  endtask

  function automatic logic [25:0] exp_vec();
    logic [3:0] g, d;
    logic [7:0] e, l;
    logic er;
    g = '0; d = '0; e = '0; l = '0; er = 1'b0;
    if (m_p != 0) begin
      if (m_rej) begin
        d[m_w] = 1'b1;
        er = 1'b1;
      end else begin
        g[m_w] = 1'b1;
        if (m_p <= 2) e[m_src] = 1'b1;
        if (m_p == 2) l[m_dst] = 1'b1;
        if (m_p == 3) d[m_w] = 1'b1;
      end
    end
    return {(m_p != 0), er, d, g, e, l};
  endfunction

  // One clock: the register file loads from what E/L showed during the cycle, then the model advances.
  task automatic step();
    logic [7:0] ce, cl;
    logic inv;
    ce = E;
    cl = L;
    @(posedge clk);
    if (clr) begin
      if (cl != 8'b0) regs[oh_idx(cl)] = regs[oh_idx(ce)];
      model_edge();
    end else begin
      model_reset();
    end
    #1;
    chk("outputs_vs_model", {6'b0, busy, err, done, gnt, E, L}, {6'b0, exp_vec()});
    inv = $onehot0(E) && $onehot0(L) && $onehot0(gnt) && $onehot0(done)
          && ((L == 8'b0) || ((E != 8'b0) && ((E & L) == 8'b0)));
    chk("invariants", {31'b0, inv}, 32'd1);
  endtask

  task automatic set_ids(input int i, input int s, input int d);
    src_id[i*3 +: 3] = 3'(s);
    dst_id[i*3 +: 3] = 3'(d);
  endtask

  initial begin
    int c, n;
    logic [3:0] d_seen;
    logic e_seen, found;
    logic [7:0] saved;
    int exp_order [5];

    tbl[0] = '{4'b0001, 2, 5, 0, 0};
    tbl[1] = '{4'b0010, 3, 3, 1, 1};
    tbl[2] = '{4'b1111, 1, 4, 2, 0};
    tbl[3] = '{4'b1111, 4, 6, 3, 0};
    tbl[4] = '{4'b1111, 6, 1, 0, 0};
    tbl[5] = '{4'b0101, 7, 0, 2, 0};
    tbl[6] = '{4'b0101, 0, 7, 0, 0};
    tbl[7] = '{4'b1000, 5, 5, 3, 1};
    exp_order = '{0, 1, 2, 3, 0};

    clr = 1'b0; req = '0; src_id = '0; dst_id = '0;
    req6 = '0; src6 = '0; dst6 = '0;
    for (int k = 0; k < 8; k++) begin
      regs[k]   = 8'((k << 4) | 12);
      m_regs[k] = 8'((k << 4) | 12);
    end
    model_reset();

    @(posedge clk);
    #1;
    chk("reset_outputs", {6'b0, busy, err, done, gnt, E, L}, 32'd0);
    clr = 1'b1;
    step();

    // out-of-range ids against a 6-register instance
    req6 = 4'b0001; src6 = 12'h001; dst6 = 12'h007;
    step();
    chk("nreg6_oor_done", {28'b0, done6}, 32'h1);
    chk("nreg6_oor_err", {31'b0, err6}, 32'h1);
    chk("nreg6_oor_noload", {26'b0, L6 | E6}, 32'h0);
    req6 = 4'b0000;
    step();
    req6 = 4'b0001; src6 = 12'h000; dst6 = 12'h005;
    step();
    chk("nreg6_valid_noerr", {31'b0, err6}, 32'h0);
    chk("nreg6_valid_e", {26'b0, E6}, 32'h01);
    req6 = 4'b0000;
    step();
    chk("nreg6_valid_l", {26'b0, L6}, 32'h20);
    step();
    step();

    for (int t = 0; t < 8; t++) begin
      req = tbl[t].req;
      for (int i = 0; i < 4; i++) set_ids(i, tbl[t].src, tbl[t].dst);
      step();
      req = 4'b0;
      c = 0; d_seen = '0; e_seen = 1'b0;
      if (done != 4'b0) begin c = 1; d_seen = done; e_seen = err; end
      for (int k = 2; k <= 6 && c == 0; k++) begin
        step();
        if (done != 4'b0) begin c = k; d_seen = done; e_seen = err; end
      end
      chk($sformatf("vec%0d_winner", t), {28'b0, d_seen}, 32'(1 << tbl[t].w));
      chk($sformatf("vec%0d_err", t), {31'b0, e_seen}, 32'(tbl[t].err));
      chk($sformatf("vec%0d_latency", t), 32'(c), (tbl[t].err != 0) ? 32'd1 : 32'd3);
      step();
      if (t == 0) begin
        chk("single_dst_loaded", {24'b0, regs[5]}, 32'h2C);
        chk("single_src_kept", {24'b0, regs[2]}, 32'h2C);
      end
    end

    // held contention: every requester served once before the first repeats
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_ids(i, 2, 3);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done != 4'b0) begin
        if (n < 5) chk("contention_order", {28'b0, done}, 32'(1 << exp_order[n]));
        n++;
      end
    end
    chk("contention_count", 32'(n), 32'd5);
    req = 4'b0;
    step();

    // ids and req change after sampling; latched transfer must finish
    saved = regs[1];
    req = 4'b0001;
    set_ids(0, 1, 6);
    step();
    req = 4'b0;
    src_id = 12'hFFF;
    dst_id = 12'h249;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done == 4'b0001) found = 1'b1;
    end
    chk("midchange_done", {31'b0, found}, 32'd1);
    chk("midchange_dst", {24'b0, regs[6]}, {24'b0, saved});
    step();

    // reset asserted in the middle of LOAD
    saved = regs[7];
    req = 4'b0100;
    set_ids(2, 0, 7);
    step();
    req = 4'b0;
    step();
    chk("in_load_l", {24'b0, L}, 32'h80);
    #3;
    clr = 1'b0;
    #1;
    chk("reset_async_drop", {6'b0, busy, err, done, gnt, E, L}, 32'd0);
    step();
    clr = 1'b1;
    chk("reset_no_load", {24'b0, regs[7]}, {24'b0, saved});
    req = 4'b1010;
    set_ids(1, 2, 4);
    set_ids(3, 5, 6);
    step();
    chk("reset_ptr_zero", {28'b0, gnt}, 32'h2);
    req = 4'b0;
    repeat (4) step();

    for (int k = 0; k < 600; k++) begin
      req    = 4'($urandom_range(0, 15));
      src_id = 12'($urandom);
      dst_id = 12'($urandom);
      step();
    end
    req = 4'b0;
    repeat (4) step();
    for (int k = 0; k < 8; k++)
      chk($sformatf("regfile_%0d", k), {24'b0, regs[k]}, {24'b0, m_regs[k]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
